// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce_sync input-conditioning block.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        STABLE_HI = 2'd1,
        WAIT_HI   = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // Enough bits to hold 0..stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input, loadable to a known level.
module sync_chain #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the input through the chain; reset preloads every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_r <= {STAGES{INIT}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a bouncy input and accepts a new level only after it has been
// stable for STABLE_CYCLES qualifying samples; emits one-cycle edge strobes.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic sample_en,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int          CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam state_t      RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic          sync_q_s;
    logic          qualify_s;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          db_out_r, db_out_s;
    logic          rise_r, rise_s;
    logic          fall_r, fall_s;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_in),
        .q   (sync_q_s)
    );

    assign qualify_s = sample_en && (sync_q_s != db_out_r);

    // Next-state, counter and output decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        db_out_s = db_out_r;
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        case (state_r)
            STABLE_LO, STABLE_HI: begin
                if (qualify_s) begin
                    state_s = (state_r == STABLE_LO) ? WAIT_HI : WAIT_LO;
                    cnt_s   = CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            WAIT_HI, WAIT_LO: begin
                // Glitch reject wins over sample_en and over a completing count.
                if (sync_q_s == db_out_r) begin
                    state_s = (state_r == WAIT_HI) ? STABLE_LO : STABLE_HI;
                    cnt_s   = CNT_ZERO;
                end else if (sample_en) begin
                    if (cnt_r == CNT_LAST) begin
                        db_out_s = ~db_out_r;
                        rise_s   = (state_r == WAIT_HI);
                        fall_s   = (state_r == WAIT_LO);
                        state_s  = (state_r == WAIT_HI) ? STABLE_HI : STABLE_LO;
                        cnt_s    = CNT_ZERO;
                    end else begin
                        cnt_s    = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = state_r;
                    cnt_s   = cnt_r;
                end
            end
            default: begin
                state_s  = RESET_STATE;
                cnt_s    = CNT_ZERO;
                db_out_s = RESET_LEVEL;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RESET_STATE;
            cnt_r    <= CNT_ZERO;
            db_out_r <= RESET_LEVEL;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            db_out_r <= db_out_s;
            rise_r   <= rise_s;
            fall_r   <= fall_s;
        end
    end

    assign db_out     = db_out_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;

endmodule
